uart_freq_loader: RTL and testbench

- Parametrised UART command receiver that loads frequency tuning words for NUM_CH DDS channels from a serial host link.
- Deserialises 8N1 bytes and parses packets of the form header byte followed by WORD_W/8 data bytes.
- Commits each complete word atomically into that channel's output register.
- Adds framing, bad-channel and inter-byte-timeout error detection.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_byte_rx.sv | 125 ++++++++++++
 rtl/uart_freq_loader.sv | 147 ++++++++++++++
 tb/tb_uart_freq_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state types, header-field positions and error codes for the UART frequency loader.
// Parity support is compiled in with the UART_PARITY_EN macro (see uart_byte_rx).
package uart_pkg;

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_PARITY,
        B_STOP
    } byte_state_t;

    typedef enum logic {
        P_HDR,
        P_DATA
    } pkt_state_t;

    localparam int HDR_FLAG_BIT = 7;
    localparam int HDR_CH_MSB   = 3;

    localparam logic [1:0] ERR_FRAME   = 2'd0;
    localparam logic [1:0] ERR_BADCH   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_PARITY  = 2'd3;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-FF rx synchroniser and byte FSM. 8N1 by default; defining
// UART_PARITY_EN adds an even-parity bit between data bit 7 and the stop bit.
//
// state    | meaning
// B_IDLE   | line idle, waiting for a low level
// B_START  | half-bit wait, then confirm the start bit (high = glitch)
// B_DATA   | sample 8 data bits LSB first, one per bit period
// B_PARITY | sample the even-parity bit (parity builds only)
// B_STOP   | sample the stop bit, emit byte or error, back to idle
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte_data,
    output logic       o_byte_valid,
    output logic       o_byte_err,
    output logic [1:0] o_byte_err_code
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    byte_state_t      r_state, w_state_nxt;
    logic             r_rx_meta, r_rx_sync;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_par_bad, w_par_bad_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_err, w_err_nxt;
    logic [1:0]       r_err_code, w_err_code_nxt;
    logic             w_tick;

    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_tick ? r_cnt : r_cnt - CNT_W'(1);
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_par_bad_nxt  = r_par_bad;
        w_valid_nxt    = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = ERR_FRAME;
        case (r_state)
            B_IDLE: begin
                w_cnt_nxt     = CNT_HALF;
                w_par_bad_nxt = 1'b0;
                if (!r_rx_sync) w_state_nxt = B_START;
            end
            B_START: if (w_tick) begin
                w_cnt_nxt   = CNT_FULL;
                w_bit_nxt   = '0;
                w_state_nxt = r_rx_sync ? B_IDLE : B_DATA;
            end
            B_DATA: if (w_tick) begin
                w_cnt_nxt   = CNT_FULL;
                w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                w_bit_nxt   = r_bit + 3'd1;
`ifdef UART_PARITY_EN
                if (r_bit == 3'd7) w_state_nxt = B_PARITY;
`else
                if (r_bit == 3'd7) w_state_nxt = B_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            B_PARITY: if (w_tick) begin
                w_cnt_nxt     = CNT_FULL;
                w_par_bad_nxt = r_rx_sync ^ (^r_shift);
                w_state_nxt   = B_STOP;
            end
`endif
            // Leave at the stop-bit sample so back-to-back bytes are not missed.
            B_STOP: if (w_tick) begin
                w_state_nxt = B_IDLE;
                if (!r_rx_sync) begin
                    w_err_nxt = 1'b1;
                end else if (r_par_bad) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = ERR_PARITY;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_state    <= B_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_FRAME;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bad  <= w_par_bad_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    assign o_byte_data     = r_shift;
    assign o_byte_valid    = r_valid;
    assign o_byte_err      = r_err;
    assign o_byte_err_code = r_err_code;

endmodule

// File: rtl/uart_freq_loader.sv
// Loads per-channel frequency words from header+data UART packets; parity checking
// is enabled by the UART_PARITY_EN macro inside uart_byte_rx.
//
// state  | meaning
// P_HDR  | waiting for a header byte (bit7 set) naming a valid channel
// P_DATA | collecting WORD_W/8 little-endian data bytes under an idle timeout
module uart_freq_loader
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 521,
    parameter  int NUM_CH       = 2,
    parameter  int WORD_W       = 16,
    parameter  int TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rx,
    output logic [NUM_CH*WORD_W-1:0] o_freq,
    output logic                     o_done,
    output logic [CH_W-1:0]          o_done_ch,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic                     o_busy
);

    localparam int NB    = WORD_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TIMEOUT_CLKS - 1);

    logic [7:0]                    w_byte_data;
    logic                          w_byte_valid, w_byte_err;
    logic [1:0]                    w_byte_err_code;
    pkt_state_t                    r_state, w_state_nxt;
    logic [CH_W-1:0]               r_ch;
    logic [IDX_W-1:0]              r_idx;
    logic [GAP_W-1:0]              r_gap;
    logic [WORD_W-1:0]             r_asm, w_word;
    logic [NUM_CH-1:0][WORD_W-1:0] r_freq;
    logic                          r_done, w_done_nxt;
    logic [CH_W-1:0]               r_done_ch;
    logic                          r_err, w_err_nxt;
    logic [1:0]                    r_err_code, w_err_code_nxt;
    logic                          w_hdr, w_ch_ok, w_last;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
        .clk             (clk),
        .rst             (rst),
        .i_rx            (i_rx),
        .o_byte_data     (w_byte_data),
        .o_byte_valid    (w_byte_valid),
        .o_byte_err      (w_byte_err),
        .o_byte_err_code (w_byte_err_code)
    );

    assign w_hdr   = w_byte_data[HDR_FLAG_BIT];
    assign w_ch_ok = 32'(w_byte_data[HDR_CH_MSB:0]) < NUM_CH;
    assign w_last  = (r_idx == IDX_W'(NB - 1));

    always_comb begin
        w_word                = r_asm;
        w_word[WORD_W-8 +: 8] = w_byte_data;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = ERR_FRAME;
        case (r_state)
            P_HDR: begin
                if (w_byte_valid && w_hdr) begin
                    if (w_ch_ok) begin
                        w_state_nxt = P_DATA;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_BADCH;
                    end
                end else if (w_byte_err) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_byte_err_code;
                end
            end
            P_DATA: begin
                // A byte arriving on the timeout cycle takes precedence.
                if (w_byte_valid) begin
                    if (w_last) begin
                        w_state_nxt = P_HDR;
                        w_done_nxt  = 1'b1;
                    end
                end else if (w_byte_err) begin
                    w_state_nxt    = P_HDR;
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_byte_err_code;
                end else if (r_gap == '0) begin
                    w_state_nxt    = P_HDR;
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                end
            end
            default: w_state_nxt = P_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= P_HDR;
            r_ch       <= '0;
            r_idx      <= '0;
            r_gap      <= '0;
            r_asm      <= '0;
            r_freq     <= '0;
            r_done     <= 1'b0;
            r_done_ch  <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_FRAME;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_done_ch  <= w_done_nxt ? r_ch : '0;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            if (r_state == P_HDR) begin
                r_idx <= '0;
                r_gap <= GAP_LOAD;
                if (w_state_nxt == P_DATA) r_ch <= w_byte_data[CH_W-1:0];
            end else if (w_byte_valid) begin
                for (int b = 0; b < NB; b++)
                    if (r_idx == IDX_W'(b)) r_asm[b*8 +: 8] <= w_byte_data;
                r_idx <= r_idx + IDX_W'(1);
                r_gap <= GAP_LOAD;
                if (w_last) r_freq[r_ch] <= w_word;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    assign o_freq     = r_freq;
    assign o_done     = r_done;
    assign o_done_ch  = r_done_ch;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_busy     = (r_state == P_DATA);

endmodule

// File: tb/tb_uart_freq_loader.sv
// Bench for uart_freq_loader: directed UART packets against a packet-level model checked
// every cycle, plus literal checks. Define UART_PARITY_EN to exercise the parity build.
module tb_uart_freq_loader;

    localparam int CPB  = 16;
    localparam int NCH  = 4;
    localparam int WW   = 24;
    localparam int TO   = 320;
    localparam int HALF = (CPB - 1) / 2;
    localparam int NB   = WW / 8;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam int LAT      = 172;
`else
    localparam int PAR_BITS = 0;
    localparam int LAT      = 156;
`endif
    // Start-bit drive to the cycle the packet layer reacts: 2 sync + detect + half bit + bits + 1
    localparam int V_OFS = 5 + HALF + (9 + PAR_BITS) * CPB;

    typedef struct {
        int         v;
        logic [7:0] d;
        bit         stop_ok;
        bit         par_ok;
    } sent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic [NCH*WW-1:0] freq;
    logic              done;
    logic [1:0]        done_ch;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    sent_t sched [0:255];
    int    n_sched = 0;
    int    rd = 0;

    logic [NCH*WW-1:0] m_freq = '0;
    bit                m_busy = 1'b0;
    int                m_ch, m_n, m_deadline;
    logic [WW-1:0]     m_word;

    int done_cnt = 0;
    int last_done_cyc = 0;
    int last_done_ch = 0;
    int last_err_cyc = 0;
    int err_cnt [4] = '{0, 0, 0, 0};

    uart_freq_loader #(
        .CLKS_PER_BIT (CPB),
        .NUM_CH       (NCH),
        .WORD_W       (WW),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (rx),
        .o_freq     (freq),
        .o_done     (done),
        .o_done_ch  (done_ch),
        .o_err      (err),
        .o_err_code (err_code),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Packet-level model stepped once per cycle, then compared with the DUT outputs.
    always @(negedge clk) begin
        bit         e_done, e_err;
        logic [1:0] e_code, e_ch;
        sent_t      s;
        if (rst) begin
            m_busy = 1'b0;
            m_freq = '0;
            rd     = n_sched;
            n_vec++;
            if (freq !== '0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
                done_ch !== 2'd0 || err_code !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_state cyc=%0d: freq=%h done=%b err=%b busy=%b done_ch=%0d err_code=%0d, want all 0",
                         cyc, freq, done, err, busy, done_ch, err_code);
            end
        end else begin
            e_done = 1'b0; e_err = 1'b0; e_code = 2'd0; e_ch = 2'd0;
            if (rd < n_sched && sched[rd].v == cyc) begin
                s = sched[rd];
                rd++;
                if (!s.stop_ok || !s.par_ok) begin
                    e_err  = 1'b1;
                    e_code = !s.stop_ok ? 2'd0 : 2'd3;
                    m_busy = 1'b0;
                end else if (!m_busy) begin
                    if (s.d[7]) begin
                        if (int'(s.d[3:0]) < NCH) begin
                            m_busy     = 1'b1;
                            m_ch       = int'(s.d[3:0]);
                            m_n        = 0;
                            m_word     = '0;
                            m_deadline = cyc + TO;
                        end else begin
                            e_err  = 1'b1;
                            e_code = 2'd1;
                        end
                    end
                end else begin
                    m_word     = m_word | (WW'(s.d) << (8 * m_n));
                    m_n++;
                    m_deadline = cyc + TO;
                    if (m_n == NB) begin
                        m_freq[m_ch*WW +: WW] = m_word;
                        e_done = 1'b1;
                        e_ch   = 2'(m_ch);
                        m_busy = 1'b0;
                    end
                end
            end else if (m_busy && cyc == m_deadline) begin
                e_err  = 1'b1;
                e_code = 2'd2;
                m_busy = 1'b0;
            end
            n_vec++;
            if (done !== e_done || err !== e_err || busy !== m_busy || freq !== m_freq ||
                (e_done && done_ch !== e_ch) || (e_err && err_code !== e_code)) begin
                n_bad++;
                $display("FAIL model_cmp cyc=%0d: got done=%b ch=%0d err=%b code=%0d busy=%b freq=%h; want done=%b ch=%0d err=%b code=%0d busy=%b freq=%h",
                         cyc, done, done_ch, err, err_code, busy, freq,
                         e_done, e_ch, e_err, e_code, m_busy, m_freq);
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                last_done_ch  = int'(done_ch);
            end
            if (err) begin
                err_cnt[err_code]++;
                last_err_cyc = cyc;
            end
        end
    end

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        sent_t s;
        s.v       = cyc + V_OFS;
        s.d       = d;
        s.stop_ok = stop_ok;
        s.par_ok  = par_ok;
        sched[n_sched] = s;
        n_sched++;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_PARITY_EN
        drive((^d) ^ !par_ok, CPB);
`endif
        if (stop_ok) begin
            drive(1'b1, CPB);
        end else begin
            drive(1'b0, 12);
            drive(1'b1, CPB - 12);
        end
    endtask

    task automatic send(input logic [7:0] d);
        send_byte(d, 1'b1, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cyc=%0d, want bench completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, e0, d0;
        rst = 1'b0;
        rx  = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_freq", 96'(freq), 96'h0);
        rst = 1'b0;
        drive(1'b1, 20);

        // Channel 2 load, back-to-back bytes
        send(8'h82); send(8'h56); send(8'h34);
        n0 = cyc;
        send(8'h12);
        drive(1'b1, 10);
        check("t1_freq", 96'(freq), 96'h000000_123456_000000_000000);
        check("t1_done_cnt", 96'(done_cnt), 96'd1);
        check("t1_done_ch", 96'(last_done_ch), 96'd2);
        check("t1_latency", 96'(last_done_cyc), 96'(n0 + LAT));

        // Bad channel header, trailing data ignored
        send(8'h85); send(8'h11);
        drive(1'b1, 10);
        check("t2_badch_cnt", 96'(err_cnt[1]), 96'd1);
        check("t2_done_cnt", 96'(done_cnt), 96'd1);
        check("t2_freq", 96'(freq), 96'h000000_123456_000000_000000);

        // Inter-byte timeout, then a clean reload of channel 1
        send(8'h81);
        n0 = cyc;
        send(8'hAA);
        drive(1'b1, 400);
        check("t3_timeout_cnt", 96'(err_cnt[2]), 96'd1);
        check("t3_timeout_cyc", 96'(last_err_cyc), 96'(n0 + LAT + 320));
        send(8'h81); send(8'h01); send(8'h02); send(8'h03);
        drive(1'b1, 10);
        check("t3_freq1", 96'(freq[47:24]), 96'h030201);
        check("t3_done_ch", 96'(last_done_ch), 96'd1);

        // Framing error mid-packet, then normal load of channel 0 with bit7-set data
        send(8'h80); send(8'h9F);
        send_byte(8'h55, 1'b0, 1'b1);
        drive(1'b1, 2 * CPB);
        check("t4_frame_cnt", 96'(err_cnt[0]), 96'd1);
        check("t4_freq0_kept", 96'(freq[23:0]), 96'h0);
        send(8'h80); send(8'hEF); send(8'hBE); send(8'hAD);
        drive(1'b1, 10);
        check("t4_freq", 96'(freq), 96'h000000_123456_030201_ADBEEF);

        // Short low glitch while idle
        e0 = err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3];
        d0 = done_cnt;
        drive(1'b0, 4);
        drive(1'b1, 40);
        check("t5_glitch_err", 96'(err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3]), 96'(e0));
        check("t5_glitch_done", 96'(done_cnt), 96'(d0));

        // Reset in the middle of a packet, then a full load of channel 3
        send(8'h83); send(8'h11); send(8'h22);
        check("t6_busy_mid", 96'(busy), 96'd1);
        rst = 1'b1;
        drive(1'b1, 1);
        check("t6_rst_freq", 96'(freq), 96'h0);
        check("t6_rst_busy", 96'(busy), 96'd0);
        drive(1'b1, 2);
        rst = 1'b0;
        drive(1'b1, 5);
        send(8'h83); send(8'h44); send(8'h55); send(8'h66);
        drive(1'b1, 10);
        check("t6_freq", 96'(freq), 96'h665544_000000_000000_000000);

`ifdef UART_PARITY_EN
        // Parity error on header, then stop+parity both bad, then a correct packet
        send_byte(8'h83, 1'b1, 1'b0);
        drive(1'b1, CPB);
        check("t7_parity_cnt", 96'(err_cnt[3]), 96'd1);
        check("t7_parity_busy", 96'(busy), 96'd0);
        send_byte(8'h80, 1'b0, 1'b0);
        drive(1'b1, 2 * CPB);
        check("t7_both_bad_frame", 96'(err_cnt[0]), 96'd2);
        send(8'h83); send(8'h77); send(8'h88); send(8'h99);
        drive(1'b1, 10);
        check("t7_freq3", 96'(freq[95:72]), 96'h998877);
`endif

        drive(1'b1, 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
